gpr_wb_arbiter: RTL and testbench

- Writer-side companion to the ID-stage general-purpose register file. It owns the file's single write port (regWrite, rw, Wd).
- It merges two result sources onto that port: the in-order WB stage, which has priority, and the long-latency multiply/divide unit (MDU), which uses a valid/ready handshake and is buffered in a small FIFO.
- It keeps a pending-write scoreboard for MDU destinations, giving decode the stall and bypass information it needs.

---
 rtl/gpr_wb_arbiter_pkg.sv | 16 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/gpr_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared definitions for the GPR write-port arbiter: register-file geometry,
// the hard-wired zero register and the write-source tag.
package gpr_wb_arbiter_pkg;

  localparam int GPR_AW  = 5;
  localparam int NUM_GPR = 1 << GPR_AW;

  localparam logic [GPR_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MDU
  } wr_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; a pop frees a slot for a
// push on the same edge, even when full.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Owns the GPR file write port: WB results take priority, MDU results queue in
// a FIFO, and a pending scoreboard feeds decode its stall/bypass signals.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int AW         = GPR_AW,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_rd,
  input  logic [DW-1:0] mdu_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  output logic          iss_busy,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          fwd_rs,
  output logic          fwd_rt,
  output logic          regWrite,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] Wd
);

  localparam int            NGPR = 1 << AW;
  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } mdu_ent_t;

  mdu_ent_t        push_ent, pop_ent;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic            wb_sel, src_mdu;

  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   rw_q, rw_d;
  logic [DW-1:0]   wd_q, wd_d;
  wr_src_e         src_q, src_d;
  logic [NGPR-1:0] pending_q, pending_d;

  assign wb_sel    = wb_we && (wb_rd != ZERO);
  assign mdu_ready = !fifo_full;
  // Results for $0 complete the handshake but are never stored.
  assign fifo_push = mdu_valid && mdu_ready && (mdu_rd != ZERO);
  assign fifo_pop  = !wb_sel && !fifo_empty;
  assign push_ent  = '{rd: mdu_rd, data: mdu_data};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW + DW)
  ) u_mdu_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .pop_data  (pop_ent),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    reg_write_d = 1'b0;
    rw_d        = rw_q;
    wd_d        = wd_q;
    src_d       = SRC_NONE;
    if (wb_sel) begin
      reg_write_d = 1'b1;
      rw_d        = wb_rd;
      wd_d        = wb_data;
      src_d       = SRC_WB;
    end else if (!fifo_empty) begin
      reg_write_d = 1'b1;
      rw_d        = pop_ent.rd;
      wd_d        = pop_ent.data;
      src_d       = SRC_MDU;
    end
  end

  assign src_mdu = (src_q == SRC_MDU);

  always_comb begin
    pending_d = pending_q;
    if (reg_write_q && src_mdu) pending_d[rw_q] = 1'b0;
    // NOTE: in always_comb the later blocking assignment wins, so a same-edge set overrides the clear.
    if (iss_valid && (iss_rd != ZERO)) pending_d[iss_rd] = 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q <= 1'b0;
      rw_q        <= '0;
      wd_q        <= '0;
      src_q       <= SRC_NONE;
      pending_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rw_q        <= rw_d;
      wd_q        <= wd_d;
      src_q       <= src_d;
      pending_q   <= pending_d;
    end
  end

  assign regWrite = reg_write_q;
  assign rw       = rw_q;
  assign Wd       = wd_q;

  assign fwd_rs   = reg_write_q && (rw_q == rs) && (rs != ZERO);
  assign fwd_rt   = reg_write_q && (rw_q == rt) && (rt != ZERO);
  // A committing MDU write is the value decode was waiting for, so bypass clears the stall.
  assign rs_busy  = pending_q[rs] && !(fwd_rs && src_mdu);
  assign rt_busy  = pending_q[rt] && !(fwd_rt && src_mdu);
  assign iss_busy = pending_q[iss_rd];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios followed by a
// randomized run compared against a queue-based reference model.
module tb_gpr_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_we, mdu_valid, iss_valid;
  logic [AW-1:0] wb_rd, mdu_rd, iss_rd, rs, rt;
  logic [DW-1:0] wb_data, mdu_data;
  logic          mdu_ready, iss_busy, rs_busy, rt_busy, fwd_rs, fwd_rt, regWrite;
  logic [AW-1:0] rw;
  logic [DW-1:0] Wd;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.FIFO_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_busy(iss_busy),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .regWrite(regWrite), .rw(rw), .Wd(Wd)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs = '0; rt = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (3) tick();
    reset = 1'b1;
    settle();
    if (regWrite !== 1'b0) begin $display("FAIL reset_regwrite: got %0b want 0", regWrite); miscompares++; end vectors++;
    if (rw !== 5'd0) begin $display("FAIL reset_rw: got %0d want 0", rw); miscompares++; end vectors++;
    if (Wd !== 32'd0) begin $display("FAIL reset_wd: got %h want 0", Wd); miscompares++; end vectors++;
    if (mdu_ready !== 1'b1) begin $display("FAIL reset_ready: got %0b want 1", mdu_ready); miscompares++; end vectors++;
    if ({iss_busy, rs_busy, rt_busy, fwd_rs, fwd_rt} !== 5'b0) begin
      $display("FAIL reset_busy: got %b want 00000", {iss_busy, rs_busy, rt_busy, fwd_rs, fwd_rt}); miscompares++;
    end vectors++;
  endtask

  task automatic test_wb_write();
    tick();
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h1234; rs = 5'd8; rt = 5'd3;
    tick();
    wb_rd = 5'd0; wb_data = 32'hFFFF;
    settle();
    if (regWrite !== 1'b1) begin $display("FAIL wb_regwrite: got %0b want 1", regWrite); miscompares++; end vectors++;
    if (rw !== 5'd8) begin $display("FAIL wb_rw: got %0d want 8", rw); miscompares++; end vectors++;
    if (Wd !== 32'h1234) begin $display("FAIL wb_wd: got %h want 00001234", Wd); miscompares++; end vectors++;
    if (fwd_rs !== 1'b1 || fwd_rt !== 1'b0) begin $display("FAIL wb_fwd: got rs=%0b rt=%0b want rs=1 rt=0", fwd_rs, fwd_rt); miscompares++; end vectors++;
    tick();
    idle(); rs = 5'd8;
    settle();
    if (regWrite !== 1'b0) begin $display("FAIL wb_zero_bubble: got %0b want 0", regWrite); miscompares++; end vectors++;
    if (rw !== 5'd8 || Wd !== 32'h1234) begin $display("FAIL wb_hold: got rw=%0d wd=%h want rw=8 wd=00001234", rw, Wd); miscompares++; end vectors++;
    if (fwd_rs !== 1'b0) begin $display("FAIL wb_nofwd: got %0b want 0", fwd_rs); miscompares++; end vectors++;
  endtask

  task automatic test_mdu_priority();
    tick();
    idle(); iss_valid = 1'b1; iss_rd = 5'd9; rs = 5'd9;
    tick();
    iss_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'hDEAD;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h333;
    settle();
    if (mdu_ready !== 1'b1) begin $display("FAIL prio_ready: got %0b want 1", mdu_ready); miscompares++; end vectors++;
    if (iss_busy !== 1'b1) begin $display("FAIL prio_iss_busy: got %0b want 1", iss_busy); miscompares++; end vectors++;
    if (rs_busy !== 1'b1) begin $display("FAIL prio_rs_busy_c1: got %0b want 1", rs_busy); miscompares++; end vectors++;
    for (int i = 0; i < 2; i++) begin
      tick();
      mdu_valid = 1'b0;
      settle();
      if (rs_busy !== 1'b1) begin $display("FAIL prio_rs_busy_wb%0d: got %0b want 1", i, rs_busy); miscompares++; end vectors++;
    end
    tick();
    wb_we = 1'b0;
    settle();
    if (rs_busy !== 1'b1 || rw !== 5'd3) begin $display("FAIL prio_wb_last: got busy=%0b rw=%0d want busy=1 rw=3", rs_busy, rw); miscompares++; end vectors++;
    tick();
    settle();
    if ({regWrite, rw, Wd} !== {1'b1, 5'd9, 32'hDEAD}) begin
      $display("FAIL prio_mdu_commit: got we=%0b rw=%0d wd=%h want we=1 rw=9 wd=0000dead", regWrite, rw, Wd); miscompares++;
    end vectors++;
    if (rs_busy !== 1'b0 || fwd_rs !== 1'b1) begin $display("FAIL prio_mdu_fwd: got busy=%0b fwd=%0b want busy=0 fwd=1", rs_busy, fwd_rs); miscompares++; end vectors++;
    tick();
    settle();
    if ({regWrite, rs_busy, iss_busy} !== 3'b000) begin
      $display("FAIL prio_cleared: got we/rs_busy/iss_busy=%b want 000", {regWrite, rs_busy, iss_busy}); miscompares++;
    end vectors++;
  endtask

  task automatic test_fifo_order();
    logic [AW-1:0] exp_rd [3];
    logic [DW-1:0] exp_dt [3];
    logic [AW-1:0] got_rd [$];
    logic [DW-1:0] got_dt [$];
    logic          accepted;
    exp_rd = '{5'd10, 5'd11, 5'd12};
    exp_dt = '{32'hA1, 32'hA2, 32'hA3};
    tick();
    idle(); wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    mdu_valid = 1'b1; mdu_rd = exp_rd[0]; mdu_data = exp_dt[0];
    settle();
    if (mdu_ready !== 1'b1) begin $display("FAIL order_ready_1st: got %0b want 1", mdu_ready); miscompares++; end vectors++;
    tick();
    mdu_rd = exp_rd[1]; mdu_data = exp_dt[1];
    settle();
    if (mdu_ready !== 1'b1) begin $display("FAIL order_ready_2nd: got %0b want 1", mdu_ready); miscompares++; end vectors++;
    tick();
    mdu_rd = exp_rd[2]; mdu_data = exp_dt[2];
    settle();
    if (mdu_ready !== 1'b0) begin $display("FAIL order_full: got %0b want 0", mdu_ready); miscompares++; end vectors++;
    tick();
    settle();
    if (mdu_ready !== 1'b0) begin $display("FAIL order_third_waits: got %0b want 0", mdu_ready); miscompares++; end vectors++;
    accepted = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      wb_we = 1'b0;
      mdu_valid = !accepted;
      settle();
      if (regWrite && rw != 5'd4) begin got_rd.push_back(rw); got_dt.push_back(Wd); end
      if (mdu_valid && mdu_ready) accepted = 1'b1;
    end
    mdu_valid = 1'b0;
    if (accepted !== 1'b1) begin $display("FAIL order_third_timeout: accepted=%0b want 1", accepted); miscompares++; end vectors++;
    if (got_rd.size() != 3) begin $display("FAIL order_count: got %0d mdu writes want 3", got_rd.size()); miscompares++; end vectors++;
    for (int k = 0; k < got_rd.size() && k < 3; k++) begin
      if (got_rd[k] !== exp_rd[k] || got_dt[k] !== exp_dt[k]) begin
        $display("FAIL order_entry%0d: got rw=%0d wd=%h want rw=%0d wd=%h", k, got_rd[k], got_dt[k], exp_rd[k], exp_dt[k]); miscompares++;
      end vectors++;
    end
  endtask

  task automatic test_set_wins();
    tick();
    idle(); iss_valid = 1'b1; iss_rd = 5'd5; rs = 5'd5;
    tick();
    iss_valid = 1'b0; mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h55;
    settle();
    if (iss_busy !== 1'b1) begin $display("FAIL setwin_pending: got %0b want 1", iss_busy); miscompares++; end vectors++;
    tick();
    mdu_valid = 1'b0;
    tick();
    iss_valid = 1'b1; iss_rd = 5'd5;
    settle();
    if ({regWrite, rw, Wd, rs_busy} !== {1'b1, 5'd5, 32'h55, 1'b0}) begin
      $display("FAIL setwin_commit: got we=%0b rw=%0d wd=%h busy=%0b want we=1 rw=5 wd=00000055 busy=0", regWrite, rw, Wd, rs_busy); miscompares++;
    end vectors++;
    tick();
    iss_valid = 1'b0;
    settle();
    if ({iss_busy, rs_busy, regWrite} !== 3'b110) begin
      $display("FAIL setwin_after: got iss_busy/rs_busy/we=%b want 110", {iss_busy, rs_busy, regWrite}); miscompares++;
    end vectors++;
  endtask

  task automatic test_reset_mid();
    tick();
    idle(); iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
    tick();
    mdu_rd = 5'd7; mdu_data = 32'h77;
    tick();
    mdu_valid = 1'b0; rs = 5'd6; rt = 5'd7; iss_rd = 5'd6;
    settle();
    if ({mdu_ready, rs_busy, rt_busy} !== 3'b011) begin
      $display("FAIL rstmid_loaded: got ready/rs_busy/rt_busy=%b want 011", {mdu_ready, rs_busy, rt_busy}); miscompares++;
    end vectors++;
    #1 reset = 1'b0;
    #1;
    if ({regWrite, rw, Wd} !== '0) begin $display("FAIL rstmid_port: got we=%0b rw=%0d wd=%h want all 0", regWrite, rw, Wd); miscompares++; end vectors++;
    if ({iss_busy, rs_busy, rt_busy, mdu_ready} !== 4'b0001) begin
      $display("FAIL rstmid_state: got iss/rs/rt busy,ready=%b want 0001", {iss_busy, rs_busy, rt_busy, mdu_ready}); miscompares++;
    end vectors++;
    idle(); rs = 5'd6; rt = 5'd7;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      settle();
      if (regWrite !== 1'b0) begin $display("FAIL rstmid_stale%0d: got we=%0b rw=%0d want we=0", c, regWrite, rw); miscompares++; end vectors++;
    end
  endtask

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  task automatic test_random();
    logic          m_we, m_mdu, e_ready, e_fwd_rs, e_fwd_rt, e_rs_busy, e_rt_busy;
    logic [AW-1:0] m_rw;
    logic [DW-1:0] m_wd;
    logic [31:0]   m_pend;
    ent_t          q [$];
    ent_t          e;
    logic [43:0]   exp_v, got_v;
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
    m_we = 1'b0; m_mdu = 1'b0; m_rw = '0; m_wd = '0; m_pend = '0;
    for (int n = 0; n < 400; n++) begin
      tick();
      wb_we     = ($urandom_range(0, 99) < 55);
      wb_rd     = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      mdu_valid = ($urandom_range(0, 99) < 40);
      mdu_rd    = AW'($urandom_range(0, 7));
      mdu_data  = $urandom;
      iss_valid = ($urandom_range(0, 99) < 25);
      iss_rd    = AW'($urandom_range(0, 7));
      rs        = AW'($urandom_range(0, 7));
      rt        = AW'($urandom_range(0, 7));
      settle();
      e_ready   = (q.size() < DEPTH);
      e_fwd_rs  = m_we && (m_rw == rs) && (rs != 0);
      e_fwd_rt  = m_we && (m_rw == rt) && (rt != 0);
      e_rs_busy = m_pend[rs] && !(e_fwd_rs && m_mdu);
      e_rt_busy = m_pend[rt] && !(e_fwd_rt && m_mdu);
      exp_v = {m_we, m_rw, m_wd, e_ready, m_pend[iss_rd], e_rs_busy, e_rt_busy, e_fwd_rs, e_fwd_rt};
      got_v = {regWrite, rw, Wd, mdu_ready, iss_busy, rs_busy, rt_busy, fwd_rs, fwd_rt};
      if (got_v !== exp_v) begin
        $display("FAIL random_cycle%0d: got %h want %h (we,rw,wd,ready,iss_busy,rs_busy,rt_busy,fwd_rs,fwd_rt)", n, got_v, exp_v); miscompares++;
      end vectors++;
      if (m_we && m_mdu) m_pend[m_rw] = 1'b0;
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      if (wb_we && wb_rd != 0) begin
        m_we = 1'b1; m_rw = wb_rd; m_wd = wb_data; m_mdu = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_rw = e.rd; m_wd = e.data; m_mdu = 1'b1;
      end else begin
        m_we = 1'b0; m_mdu = 1'b0;
      end
      if (mdu_valid && e_ready && mdu_rd != 0) q.push_back('{rd: mdu_rd, data: mdu_data});
    end
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_mdu_priority();
    test_fifo_order();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
